// File: rtl/serial_parity_checker_pkg.sv
// Shared types and constants for the serial parity checker.
package serial_parity_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/serial_parity_checker_xor.sv
// Single-bit exclusive-OR cell used to fold serial bits into a running parity.
module serial_parity_checker_xor (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises an LSB-first frame of DATA_BITS data bits plus a parity bit,
// reports the word, a parity-error flag and a saturating bad-frame count.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | waiting for a valid bit with sof
// ST_DATA   | collecting data bits 1..DATA_BITS-1
// ST_PARITY | waiting for the trailing parity bit
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 sof,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 abort,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int              CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);
    localparam logic            ODD_BIT  = (PARITY_ODD != 0);
    // A one-bit frame has no DATA phase: the start bit is the only data bit.
    localparam state_t          FIRST_ST = (DATA_BITS == 1) ? ST_PARITY : ST_DATA;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   acc_q;
    logic                   acc_nxt;

    logic                   start;
    logic                   done_d;
    logic                   abort_d;
    logic                   busy_d;
    logic                   perr_d;
    logic                   err_inc;

    assign start = bit_valid && sof;

    serial_parity_checker_xor u_xor (
        .a (acc_q),
        .b (bit_in),
        .y (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = FIRST_ST;
                end
            end
            ST_DATA: begin
                if (start) begin
                    state_d = FIRST_ST;
                end else if (bit_valid && (cnt_q == LAST_IDX)) begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (start) begin
                    state_d = FIRST_ST;
                end else if (bit_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A restart on the parity cycle suppresses done, so done and abort are exclusive.
    always_comb begin
        done_d  = (state_q == ST_PARITY) && bit_valid && !sof;
        abort_d = (state_q != ST_IDLE) && start;
        busy_d  = (state_d != ST_IDLE);
        perr_d  = acc_nxt ^ ODD_BIT;
        err_inc = done_d && perr_d && (err_count != ERR_CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
        end else if (start) begin
            cnt_q   <= CNT_W'(1);
            shift_q <= DATA_BITS'(bit_in);
            acc_q   <= bit_in;
        end else if (bit_valid && (state_q == ST_DATA)) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            shift_q <= shift_q | (DATA_BITS'(bit_in) << cnt_q);
            acc_q   <= acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            abort      <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            err_count  <= '0;
        end else begin
            busy  <= busy_d;
            done  <= done_d;
            abort <= abort_d;
            if (done_d) begin
                data_out   <= shift_q;
                parity_err <= perr_d;
            end
            if (err_inc) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: even-parity and odd-parity
// instances share one serial stimulus stream.
module tb_serial_parity_checker;

    logic       clk;
    logic       rst_n;
    logic       bit_valid;
    logic       bit_in;
    logic       sof;

    logic       busy, done, parity_err, abort;
    logic [7:0] data_out, err_count;
    logic       busy_o, done_o, parity_err_o, abort_o;
    logic [7:0] data_out_o, err_count_o;

    int checks     = 0;
    int failures   = 0;
    int abort_seen = 0;
    int done_seen  = 0;

    serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .sof        (sof),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .parity_err (parity_err),
        .abort      (abort),
        .err_count  (err_count)
    );

    serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .sof        (sof),
        .busy       (busy_o),
        .done       (done_o),
        .data_out   (data_out_o),
        .parity_err (parity_err_o),
        .abort      (abort_o),
        .err_count  (err_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic v, input logic s, input logic b);
        bit_valid = v;
        sof       = s;
        bit_in    = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        sof       = 1'b0;
        bit_in    = 1'b0;
        if (abort === 1'b1) abort_seen++;
        if (done === 1'b1)  done_seen++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int gaps, input logic chk_busy);
        step(1'b1, 1'b1, d[0]);
        if (chk_busy) check("busy_first_bit", busy, 1);
        for (int i = 1; i < 8; i++) begin
            for (int g = 0; g < gaps; g++) begin
                step(1'b0, 1'b0, 1'b0);
                if (chk_busy) check("busy_gap", busy, 1);
            end
            step(1'b1, 1'b0, d[i]);
            if (chk_busy) check("busy_data", busy, 1);
        end
        for (int g = 0; g < gaps; g++) begin
            step(1'b0, 1'b0, 1'b0);
            if (chk_busy) check("busy_gap_par", busy, 1);
        end
        step(1'b1, 1'b0, p);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic perr, input logic [7:0] cnt);
        check({tag, "_done"}, done, 1);
        check({tag, "_abort"}, abort, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_data"}, data_out, d);
        check({tag, "_perr"}, parity_err, perr);
        check({tag, "_errcnt"}, err_count, cnt);
    endtask

    initial begin
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        sof       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_abort", abort, 0);
        check("rst_data", data_out, 0);
        check("rst_perr", parity_err, 0);
        check("rst_errcnt", err_count, 0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        check("no_sof_ignored", busy, 0);

        // 0xA5 has four ones: p=0 is correct under even parity
        send_frame(8'hA5, 1'b0, 0, 1'b1);
        check_frame("a5_good", 8'hA5, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0);
        check("done_one_cycle", done, 0);
        check("data_held", data_out, 8'hA5);

        send_frame(8'hA5, 1'b1, 0, 1'b0);
        check_frame("a5_bad", 8'hA5, 1'b1, 8'd1);
        send_frame(8'h3C, 1'b0, 0, 1'b0);
        check_frame("3c_b2b", 8'h3C, 1'b0, 8'd1);

        send_frame(8'h01, 1'b0, 0, 1'b0);
        check("odd_01_perr", parity_err_o, 0);
        check("odd_01_done", done_o, 1);
        check_frame("even_01", 8'h01, 1'b1, 8'd2);
        send_frame(8'h03, 1'b0, 0, 1'b0);
        check("odd_03_perr", parity_err_o, 1);
        check("odd_03_data", data_out_o, 8'h03);
        check_frame("even_03", 8'h03, 1'b0, 8'd2);

        send_frame(8'hA5, 1'b0, 2, 1'b1);
        check_frame("a5_gaps", 8'hA5, 1'b0, 8'd2);

        abort_seen = 0;
        done_seen  = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 0, 1'b0);
        check_frame("abort_ff", 8'hFF, 1'b0, 8'd2);
        check("abort_pulses", abort_seen, 1);
        check("abort_dones", done_seen, 1);

        // sof landing on the parity-bit cycle restarts instead of completing
        abort_seen = 0;
        done_seen  = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 0, 1'b0);
        check_frame("sof_on_parity", 8'h5A, 1'b0, 8'd2);
        check("sofpar_aborts", abort_seen, 1);
        check("sofpar_dones", done_seen, 1);

        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_errcnt", err_count, 0);
        check("mid_rst_perr", parity_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h3C, 1'b0, 0, 1'b1);
        check_frame("after_rst", 8'h3C, 1'b0, 8'd0);

        for (int i = 1; i <= 260; i++) begin
            send_frame(8'hA5, 1'b1, 0, 1'b0);
            if (i == 254) check("sat_254", err_count, 254);
            if (i == 255) check("sat_255", err_count, 255);
        end
        check_frame("sat_260", 8'hA5, 1'b1, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
